// File: rtl/program_loader.sv
// program_loader: boot-time loader that streams a word image into MEMORY.
//
// Byte stream format: one count byte N (N=0 means 2^ADDR_WIDTH words), then
// N 16-bit words sent high byte first. Each assembled word is written through
// the MAR/data/EN/CS port in a single one-cycle WRITE. The CPU is held stopped
// (cpu_run=0) until the session completes.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   When defined, one extra byte follows the last word. It must equal the XOR
//   of the count byte and every data byte. A mismatch ends in ERROR. Words
//   already written stay in memory.
//   When undefined, there is no CHECK state and error is tied to 0.
//
// Handshake: a byte transfers on a rising edge where in_valid and in_ready are
// both 1. in_ready is registered and depends only on state, never on in_valid.
// The sender may hold in_valid low for any length of time; the loader waits.
//
// The count byte is zero-extended into an ADDR_WIDTH+1 bit counter, so
// ADDR_WIDTH must be at least 7.

module program_loader #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_en,
  output logic                  mem_cs,
  output logic                  cpu_run,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded,
  output logic [2:0]            debug_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_GET_COUNT = 3'd1,
    S_GET_HI    = 3'd2,
    S_GET_LO    = 3'd3,
    S_WRITE     = 3'd4,
    S_CHECK     = 3'd5,
    S_DONE      = 3'd6,
    S_ERROR     = 3'd7
  } state_e;

  // A count byte of zero stands for the full address space.
  localparam logic [ADDR_WIDTH:0] CNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] WL_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_e                  state_q, state_d;
  logic                    in_ready_q;
  logic                    busy_q;
  logic                    mem_cs_q;
  logic                    mem_en_q;
  logic                    done_q;
  logic                    cpu_run_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_data_q;
  logic [7:0]              hi_q;
  logic [ADDR_WIDTH:0]     count_q;
  logic [ADDR_WIDTH:0]     words_loaded_q;
  logic [ADDR_WIDTH:0]     words_next;
  logic                    accept;
  logic                    session_start;

`ifdef LOADER_CHECKSUM_EN
  logic                    error_q;
  logic [7:0]              csum_q;
`endif

  // A byte is consumed only in a receiving state with the sender offering one.
  assign accept        = in_ready_q & in_valid;
  // start is honoured only while no session is in progress.
  assign session_start = start & ~busy_q;
  assign words_next    = words_loaded_q + WL_ONE;

  // Next-state selection for the load sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_d = S_GET_COUNT;
      end
      S_GET_COUNT: begin
        if (accept) state_d = S_GET_HI;
      end
      S_GET_HI: begin
        if (accept) state_d = S_GET_LO;
      end
      S_GET_LO: begin
        if (accept) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (words_next < count_q) begin
          state_d = S_GET_HI;
        end else begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) state_d = (in_data == csum_q) ? S_DONE : S_ERROR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State register, registered Moore outputs and the load datapath.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      in_ready_q     <= 1'b0;
      busy_q         <= 1'b0;
      mem_cs_q       <= 1'b0;
      mem_en_q       <= 1'b0;
      done_q         <= 1'b0;
      cpu_run_q      <= 1'b0;
      mem_addr_q     <= START_ADDR;
      mem_data_q     <= '0;
      hi_q           <= 8'd0;
      count_q        <= '0;
      words_loaded_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      error_q        <= 1'b0;
      csum_q         <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      // Outputs are decoded from the state being entered so that they line
      // up with state_q in the following cycle without a combinational path.
      in_ready_q <= (state_d == S_GET_COUNT) || (state_d == S_GET_HI) ||
                    (state_d == S_GET_LO)    || (state_d == S_CHECK);
      busy_q     <= !((state_d == S_IDLE) || (state_d == S_DONE) ||
                      (state_d == S_ERROR));
      mem_cs_q   <= (state_d == S_WRITE);
      mem_en_q   <= (state_d == S_WRITE);
      done_q     <= (state_d == S_DONE);
      cpu_run_q  <= (state_d == S_DONE);
`ifdef LOADER_CHECKSUM_EN
      error_q    <= (state_d == S_ERROR);
`endif

      // A new session restarts addressing and counting from scratch.
      if (session_start) begin
        mem_addr_q     <= START_ADDR;
        words_loaded_q <= '0;
`ifdef LOADER_CHECKSUM_EN
        csum_q         <= 8'd0;
`endif
      end

      if (accept) begin
`ifdef LOADER_CHECKSUM_EN
        if (state_q != S_CHECK) csum_q <= csum_q ^ in_data;
`endif
        case (state_q)
          S_GET_COUNT: begin
            count_q <= (in_data == 8'd0) ? CNT_MAX
                                         : {{(ADDR_WIDTH-7){1'b0}}, in_data};
          end
          S_GET_HI: hi_q <= in_data;
          // mem_data only changes here, so it holds steady outside WRITE.
          S_GET_LO: mem_data_q <= {hi_q, in_data};
          default: ;
        endcase
      end

      // The write completes at the edge leaving WRITE; advance past it.
      if (state_q == S_WRITE) begin
        mem_addr_q     <= mem_addr_q + ADDR_ONE;
        words_loaded_q <= words_next;
      end
    end
  end

  assign in_ready     = in_ready_q;
  assign busy         = busy_q;
  assign mem_cs       = mem_cs_q;
  assign mem_en       = mem_en_q;
  assign done         = done_q;
  assign cpu_run      = cpu_run_q;
  assign mem_addr     = mem_addr_q;
  assign mem_data     = mem_data_q;
  assign words_loaded = words_loaded_q;
  assign debug_state  = state_q;
`ifdef LOADER_CHECKSUM_EN
  assign error        = error_q;
`else
  assign error        = 1'b0;
`endif

endmodule
